// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } muldiv_state_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Wide enough for a 2*WIDTH product with WIDTH up to 64; callers size-cast in and out.
    localparam int NEG_W = 128;

    function automatic logic [NEG_W-1:0] neg(input logic [NEG_W-1:0] x);
        return ~x + NEG_W'(1);
    endfunction

    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return op_a_signed(op) && (op != OP_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with sign fix-up after the last step and a single-cycle path for divide-by-zero and overflow.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return WIDTH'(neg(NEG_W'(x)));
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return (2*WIDTH)'(neg(NEG_W'(x)));
    endfunction

    muldiv_state_e      state;
    muldiv_op_e         op;
    logic [CW-1:0]      count;
    logic               res_neg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;

    muldiv_op_e         req_op;
    logic               sign_a, sign_b, req_sign, req_div, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b, fast_res;

    assign req_op = muldiv_op_e'(funct3);

    // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
    always_comb begin
        req_div  = funct3[2];
        sign_a   = op_a[WIDTH-1] & op_a_signed(req_op);
        sign_b   = op_b[WIDTH-1] & op_b_signed(req_op);
        mag_a    = sign_a ? neg_w(op_a) : op_a;
        mag_b    = sign_b ? neg_w(op_b) : op_b;
        // Remainder takes the dividend's sign; everything else the XOR of both.
        req_sign = (req_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = req_div && (op_b == '0);
        div_ovf  = req_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        fast_res = '0;
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            fast_res = funct3[1] ? '0 : op_a;
        end
    end

    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, divisor};
        if (op[2]) begin
            acc_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = res_neg ? neg_2w(acc) : acc;
        quo_fix  = res_neg ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = res_neg ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        case (op)
            OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    // NOTE: only control state and result are reset; the datapath registers are always
    // loaded at acceptance before being read, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            result <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op      <= req_op;
                        res_neg <= req_sign;
                        count   <= '0;
                        divisor <= mag_b;
                        acc     <= {{WIDTH{1'b0}}, mag_a};
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH-1)) state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    result <= fix_res;
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_CALC) || (state == ST_FIXUP);
    assign done  = (state == ST_DONE);
    assign stall = !reset && (((state == ST_IDLE) && start && !flush) || busy);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: drivers queue expected results and done cycles,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done pulsed at cycle %0d with nothing pending", cyc);
            end else begin
                automatic logic [31:0] ev = exp_q.pop_front();
                automatic int          ec = cyc_q.pop_front();
                automatic string       nm = name_q.pop_front();
                check({nm, "_result"}, result, ev);
                check({nm, "_cycle"}, 32'(cyc), 32'(ec));
            end
        end
    end

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
    endtask

    task automatic expect_at(input string name, input logic [31:0] expv, input int at_cyc);
        exp_q.push_back(expv);
        cyc_q.push_back(at_cyc);
        name_q.push_back(name);
    endtask

    // Waits (bounded) for done; stall must be the complement of done over the whole op.
    task automatic finish_op(input string name, input bit drop);
        int sbad = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (stall !== ~done) sbad++;
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_stall_window"}, 32'(sbad), 32'd0);
        @(posedge clk);
        #1;
        if (drop) start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int lat);
        @(posedge clk);
        #1;
        launch(f3, a, b);
        expect_at(name, expv, cyc + lat);
        finish_op(name, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        start = 1'b1;
        #1;
        check("rst_stall_forced", {31'b0, stall}, 32'h0);
        start = 1'b0;
        reset = 1'b0;

        run_op("mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulhu_max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op("mulhsu_m1_2",   3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("mulh_min_min",  3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        run_op("mul_shift",     3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, 34);
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu_100_7",    3'b101, 32'd100,        32'd7,         32'd14,        34);
        run_op("remu_100_7",    3'b111, 32'd100,        32'd7,         32'd2,         34);
        run_op("div_20_m6",     3'b100, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 34);
        run_op("rem_20_m6",     3'b110, 32'd20,         32'hFFFF_FFFA, 32'd2,         34);
        run_op("divu_max_1",    3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34);
        run_op("div_min_1",     3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 34);
        run_op("divu_5_0",      3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_5_0",       3'b110, 32'd5,          32'd0,         32'd5,         1);
        run_op("div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);

        // start held through DONE: one done, then re-accepted in the following IDLE cycle.
        @(posedge clk);
        #1;
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        expect_at("b2b_first", 32'hFFFF_FFEB, cyc + 34);
        expect_at("b2b_second", 32'hFFFF_FFEB, cyc + 69);
        finish_op("b2b_first", 1'b0);
        finish_op("b2b_second", 1'b1);

        // Flush a DIV in cycle 10, then start a MUL in cycle 11.
        @(posedge clk);
        #1;
        launch(3'b100, 32'd1000, 32'd3);
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_before", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_after", {31'b0, busy}, 32'h0);
        launch(3'b000, 32'd100, 32'd3);
        expect_at("mul_after_flush", 32'd300, t0 + 45);
        finish_op("mul_after_flush", 1'b1);

        // Reset in cycle 20 of a MUL, start still held.
        @(posedge clk);
        #1;
        launch(3'b000, 32'h1234_5678, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_busy_before", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid_stall_forced", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_done", {31'b0, done}, 32'h0);
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(posedge clk);

        run_op("mul_after_reset", 3'b000, 32'd12, 32'd12, 32'd144, 34);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
